// File: rtl/sha256_msg_padder_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder_if
// Purpose : groups the byte-stream input handshake and the padded-block output
//           handshake of the SHA-256 message padder.
// Signals :
//   in_valid  - producer has a message byte on in_data/in_last
//   in_ready  - padder accepts a byte this cycle
//   in_data   - message byte, first byte of the message first
//   in_last   - marks the final byte of a message
//   blk_valid - blk_data holds a complete padded 512-bit block
//   blk_ready - consumer accepts the block this cycle
//   blk_data  - padded block, message byte 0 in [511:504]
//   blk_first - block is the first of its message
//   blk_last  - block is the final block of its message
// Modports: master = byte producer / block consumer side, slave = padder.
// ---------------------------------------------------------------------------
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
// Purpose : byte-stream front end for the SHA-256 core. Collects message bytes,
//           applies the standard padding (0x80, zero fill, 64-bit big-endian
//           bit length) and hands out padded 512-bit blocks one at a time with
//           first/last flags.
// Ports   :
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low reset
//   bus     - sha256_msg_padder_if.slave (byte input + block output handshakes)
// Parameters:
//   LEN_W   - width of the message bit-length counter (<=64), zero-extended
//             into the 64-bit length field
// ---------------------------------------------------------------------------
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sha256_msg_padder_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_PADBLK = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [6:0]         r_ptr;
  logic [511:0]       r_buf;
  logic [LEN_W-1:0]   r_bit_len;
  logic               r_pend_len;
  logic               r_pend_80;
  logic               r_last;
  logic               r_first_flag;
  logic               r_in_ready;
  logic               r_blk_valid;
  logic               r_blk_first;
  logic               r_blk_last;

  logic [6:0]         w_ptr_nxt;
  logic [511:0]       w_buf_nxt;
  logic [LEN_W-1:0]   w_bit_len_nxt;
  logic               w_pend_len_nxt;
  logic               w_pend_80_nxt;
  logic               w_last_nxt;
  logic               w_first_flag_nxt;
  logic               w_in_ready_nxt;
  logic               w_blk_valid_nxt;
  logic               w_blk_first_nxt;
  logic               w_blk_last_nxt;

  logic               w_in_xfer;
  logic               w_blk_xfer;
  logic [6:0]         w_ptr_inc;
  logic [LEN_W-1:0]   w_len_inc;

  // Replace byte idx (0 = leftmost, bits [511:504]) of a block.
  function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                            input logic [5:0]   idx,
                                            input logic [7:0]   val);
    logic [511:0] res;
    res = blk;
    res[9'd504 - {idx, 3'b000} +: 8] = val;
    return res;
  endfunction

  // Zero-extend the bit-length counter into the 64-bit length field.
  function automatic logic [63:0] len_field(input logic [LEN_W-1:0] len);
    return 64'(len);
  endfunction

  // in_ready is only ever high in FILL, so it doubles as the byte-accept gate.
  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_blk_xfer = r_blk_valid & bus.blk_ready;
  assign w_ptr_inc  = r_ptr + 7'd1;
  assign w_len_inc  = r_bit_len + LEN_W'(8);

  // The block buffer is presented directly; it is frozen while a block is pending.
  assign bus.in_ready  = r_in_ready;
  assign bus.blk_valid = r_blk_valid;
  assign bus.blk_data  = r_buf;
  assign bus.blk_first = r_blk_first;
  assign bus.blk_last  = r_blk_last;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_in_xfer && (bus.in_last || (r_ptr == 7'd63))) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_EMIT: begin
        if (w_blk_xfer) begin
          if (r_pend_len) begin
            w_state_nxt = ST_PADBLK;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_PADBLK: begin
        w_state_nxt = ST_EMIT;
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    w_ptr_nxt        = r_ptr;
    w_buf_nxt        = r_buf;
    w_bit_len_nxt    = r_bit_len;
    w_pend_len_nxt   = r_pend_len;
    w_pend_80_nxt    = r_pend_80;
    w_last_nxt       = r_last;
    w_first_flag_nxt = r_first_flag;
    case (r_state)
      ST_FILL: begin
        if (w_in_xfer) begin
          w_ptr_nxt     = w_ptr_inc;
          w_bit_len_nxt = w_len_inc;
          w_buf_nxt     = put_byte(r_buf, r_ptr[5:0], bus.in_data);
          if (bus.in_last) begin
            if (w_ptr_inc <= 7'd55) begin
              // Everything fits: 0x80, zeros (buffer already clear), length.
              w_buf_nxt       = put_byte(w_buf_nxt, w_ptr_inc[5:0], 8'h80);
              w_buf_nxt[63:0] = len_field(w_len_inc);
              w_last_nxt      = 1'b1;
            end else if (w_ptr_inc <= 7'd63) begin
              // 0x80 fits but the length does not: a padding-only block follows.
              w_buf_nxt      = put_byte(w_buf_nxt, w_ptr_inc[5:0], 8'h80);
              w_pend_len_nxt = 1'b1;
              w_last_nxt     = 1'b0;
            end else begin
              // Block is full of message: the 0x80 moves to the next block too.
              w_pend_len_nxt = 1'b1;
              w_pend_80_nxt  = 1'b1;
              w_last_nxt     = 1'b0;
            end
          end else begin
            w_last_nxt = 1'b0;
          end
        end else begin
          w_ptr_nxt = r_ptr;
        end
      end
      ST_EMIT: begin
        if (w_blk_xfer) begin
          w_buf_nxt        = 512'd0;
          w_ptr_nxt        = 7'd0;
          w_last_nxt       = 1'b0;
          // The block after a final block starts a new message.
          w_first_flag_nxt = r_last;
          if (r_last) begin
            w_bit_len_nxt = '0;
          end else begin
            w_bit_len_nxt = r_bit_len;
          end
        end else begin
          w_buf_nxt = r_buf;
        end
      end
      ST_PADBLK: begin
        w_buf_nxt      = {(r_pend_80 ? 8'h80 : 8'h00), 440'd0, len_field(r_bit_len)};
        w_last_nxt     = 1'b1;
        w_pend_len_nxt = 1'b0;
        w_pend_80_nxt  = 1'b0;
      end
      default: begin
        w_ptr_nxt = 7'd0;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == ST_FILL);
    w_blk_valid_nxt = (w_state_nxt == ST_EMIT);
    if (w_state_nxt == ST_EMIT) begin
      w_blk_first_nxt = w_first_flag_nxt;
      w_blk_last_nxt  = w_last_nxt;
    end else begin
      w_blk_first_nxt = 1'b0;
      w_blk_last_nxt  = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr        <= 7'd0;
      r_buf        <= 512'd0;
      r_bit_len    <= '0;
      r_pend_len   <= 1'b0;
      r_pend_80    <= 1'b0;
      r_last       <= 1'b0;
      r_first_flag <= 1'b1;
      r_in_ready   <= 1'b0;
      r_blk_valid  <= 1'b0;
      r_blk_first  <= 1'b0;
      r_blk_last   <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_buf        <= w_buf_nxt;
      r_bit_len    <= w_bit_len_nxt;
      r_pend_len   <= w_pend_len_nxt;
      r_pend_80    <= w_pend_80_nxt;
      r_last       <= w_last_nxt;
      r_first_flag <= w_first_flag_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_blk_valid  <= w_blk_valid_nxt;
      r_blk_first  <= w_blk_first_nxt;
      r_blk_last   <= w_blk_last_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
// Self-checking bench for sha256_msg_padder: a table of messages with their
// hand-computed block counts and length fields, plus directed sequences for
// backpressure and reset in the middle of a message / pending block.
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_padder_if u_if();

  sha256_msg_padder #(.LEN_W(64)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          len;
    int          pat;
    int          nblk;
    logic [63:0] len_field;
  } vec_t;

  vec_t vecs[8];

  logic [511:0] got_data[4];
  logic         got_first[4];
  logic         got_last[4];
  int           got_n;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 416'd0, 64'h18};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [7:0] msg_byte(input int pat, input int i);
    case (pat)
      0:       return 8'h00;
      1:       return 8'h41;
      2:       return 8'(8'h61 + (i % 3));
      default: return 8'(i);
    endcase
  endfunction

  // Padded message as a flat byte sequence: message, 0x80, zeros, 64-bit length.
  function automatic logic [511:0] ref_block(input int len, input int pat, input int nblk, input int k);
    logic [511:0] b;
    logic [63:0]  bits;
    logic [7:0]   v;
    int           idx;
    int           total;
    bits  = 64'(len) * 64'd8;
    total = nblk * 64;
    b     = '0;
    for (int j = 0; j < 64; j++) begin
      idx = k * 64 + j;
      if (idx < len)              v = msg_byte(pat, idx);
      else if (idx == len)        v = 8'h80;
      else if (idx >= total - 8)  v = 8'(bits >> (8 * (total - 1 - idx)));
      else                        v = 8'h00;
      b[511 - 8*j -: 8] = v;
    end
    return b;
  endfunction

  task automatic send_msg(input int len, input int pat, input bit with_last);
    int cnt;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.in_data  = msg_byte(pat, i);
      u_if.in_last  = with_last && (i == len - 1);
      cnt = 0;
      while (!u_if.in_ready && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      if (!u_if.in_ready) begin
        timeout_fail("in_ready_wait");
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_blk, input int stall_cycles);
    int cnt;
    got_n = 0;
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      @(negedge clk);
      while (!u_if.blk_valid && cnt < 300) begin
        @(negedge clk);
        cnt++;
      end
      if (!u_if.blk_valid) begin
        timeout_fail("blk_valid_wait");
        return;
      end
      got_data[k]  = u_if.blk_data;
      got_first[k] = u_if.blk_first;
      got_last[k]  = u_if.blk_last;
      check("in_ready_low_while_valid", u_if.in_ready, 1'b0);
      if (k == stall_blk) begin
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          check($sformatf("stall%0d_valid", s), u_if.blk_valid, 1'b1);
          check($sformatf("stall%0d_data", s), u_if.blk_data, got_data[k]);
          check($sformatf("stall%0d_flags", s), {u_if.blk_first, u_if.blk_last},
                {got_first[k], got_last[k]});
          check($sformatf("stall%0d_in_ready", s), u_if.in_ready, 1'b0);
        end
      end
      u_if.blk_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      u_if.blk_ready = 1'b0;
      check("blk_valid_drops_after_handshake", u_if.blk_valid, 1'b0);
      got_n++;
    end
  endtask

  task automatic check_blocks(input string tag, input vec_t v);
    check({tag, "_nblk"}, 512'(got_n), 512'(v.nblk));
    for (int k = 0; k < got_n; k++) begin
      check($sformatf("%s_blk%0d_data", tag, k), got_data[k], ref_block(v.len, v.pat, v.nblk, k));
      check($sformatf("%s_blk%0d_first", tag, k), got_first[k], (k == 0));
      check($sformatf("%s_blk%0d_last", tag, k), got_last[k], (k == v.nblk - 1));
    end
    if (got_n == v.nblk) begin
      check({tag, "_len_field"}, got_data[got_n-1][63:0], v.len_field);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int stall_blk, input int stall_cycles);
    fork
      send_msg(v.len, v.pat, 1'b1);
      collect(v.nblk, stall_blk, stall_cycles);
    join
    check_blocks(tag, v);
    repeat (3) @(negedge clk);
    check({tag, "_idle_valid"}, u_if.blk_valid, 1'b0);
    check({tag, "_idle_in_ready"}, u_if.in_ready, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, u_if.in_ready, 1'b0);
    check({tag, "_blk_valid"}, u_if.blk_valid, 1'b0);
    check({tag, "_blk_data"}, u_if.blk_data, 512'd0);
    check({tag, "_blk_first"}, u_if.blk_first, 1'b0);
    check({tag, "_blk_last"}, u_if.blk_last, 1'b0);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_ready_before_edge"}, u_if.in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_ready_after_edge"}, u_if.in_ready, 1'b1);
  endtask

  initial begin
    vec_t abc;
    int   cnt;

    vecs[0] = '{len: 3,   pat: 2, nblk: 1, len_field: 64'h18};
    vecs[1] = '{len: 55,  pat: 0, nblk: 1, len_field: 64'h1B8};
    vecs[2] = '{len: 56,  pat: 1, nblk: 2, len_field: 64'h1C0};
    vecs[3] = '{len: 90,  pat: 2, nblk: 2, len_field: 64'h2D0};
    vecs[4] = '{len: 64,  pat: 3, nblk: 2, len_field: 64'h200};
    vecs[5] = '{len: 3,   pat: 2, nblk: 1, len_field: 64'h18};
    vecs[6] = '{len: 1,   pat: 1, nblk: 1, len_field: 64'h8};
    vecs[7] = '{len: 119, pat: 3, nblk: 2, len_field: 64'h3B8};
    abc = vecs[0];

    u_if.in_valid  = 1'b0;
    u_if.in_data   = 8'h00;
    u_if.in_last   = 1'b0;
    u_if.blk_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    #1;
    check("reset_ready_before_edge", u_if.in_ready, 1'b0);
    @(negedge clk);
    check("reset_ready_after_edge", u_if.in_ready, 1'b1);

    // Table of messages; vecs[4] followed by vecs[5] checks first after a multi-block message.
    for (int v = 0; v < 8; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v], -1, 0);
      if (v == 0 && got_n == 1) begin
        check("abc_literal", got_data[0], ABC_BLOCK);
      end
    end

    // Backpressure: hold the first block of a 56-byte message for 5 cycles.
    run_vec("stall56", vecs[2], 0, 5);

    // Reset in the middle of a message.
    send_msg(20, 1, 1'b0);
    reset_pulse("rst_mid_msg");
    run_vec("after_rst_msg", abc, -1, 0);
    if (got_n == 1) begin
      check("after_rst_msg_literal", got_data[0], ABC_BLOCK);
    end

    // Reset while a full (non-final) block is pending.
    send_msg(64, 3, 1'b0);
    cnt = 0;
    while (!u_if.blk_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("pending_block_valid", u_if.blk_valid, 1'b1);
    check("pending_block_data", u_if.blk_data, ref_block(64, 3, 1, 0));
    reset_pulse("rst_mid_emit");
    run_vec("after_rst_emit", abc, -1, 0);
    if (got_n == 1) begin
      check("after_rst_emit_literal", got_data[0], ABC_BLOCK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
